// File: rtl/fight_controller.sv
// Match sequencer for the two-fighter game: round flow, round clock, win tally
// and cooldown-gated hit arbitration feeding the two health bars.
module fight_controller #(
    parameter int ROUND_TIME     = 99,
    parameter int FRAMES_PER_SEC = 60,
    parameter int INTRO_FRAMES   = 120,
    parameter int KO_FRAMES      = 180,
    parameter int HIT_COOLDOWN   = 20,
    parameter int WINS_NEEDED    = 2,
    parameter int MAX_ROUNDS     = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [7:0] ryu_health,
    input  logic [7:0] akuma_health,
    input  logic       ryu_hit_req,
    input  logic       akuma_hit_req,
    output logic       ryu_hit,
    output logic       akuma_hit,
    output logic       health_reset,
    output logic       fight_enable,
    output logic [6:0] timer_secs,
    output logic [2:0] round_num,
    output logic [1:0] ryu_wins,
    output logic [1:0] akuma_wins,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INTRO      = 3'd1,
        FIGHT      = 3'd2,
        KO         = 3'd3,
        MATCH_OVER = 3'd4
    } state_e;

    localparam int CNT_MAX1 = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
    localparam int CNT_MAX  = (CNT_MAX1 > FRAMES_PER_SEC) ? CNT_MAX1 : FRAMES_PER_SEC;
    localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int CD_W     = $clog2(HIT_COOLDOWN + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        timer_q, timer_d;
    logic [2:0]        round_q, round_d;
    logic [1:0]        ryu_wins_q, ryu_wins_d;
    logic [1:0]        akuma_wins_q, akuma_wins_d;
    logic [1:0]        winner_q, winner_d;
    logic [CD_W-1:0]   ryu_cd_q, ryu_cd_d;
    logic [CD_W-1:0]   akuma_cd_q, akuma_cd_d;
    logic              ryu_hit_q, ryu_hit_d;
    logic              akuma_hit_q, akuma_hit_d;
    logic              health_reset_q, health_reset_d;
    logic              fight_enable_q, fight_enable_d;

    logic              enter_intro;
    logic              ko_now;
    logic              match_done;
    logic [CD_W-1:0]   ryu_cd_dec, akuma_cd_dec;

    // The tick's own decrement is applied before the grant test, so a held
    // request lands again exactly HIT_COOLDOWN ticks after the previous hit.
    assign ryu_cd_dec   = (ryu_cd_q == '0)   ? '0 : ryu_cd_q - CD_W'(1);
    assign akuma_cd_dec = (akuma_cd_q == '0) ? '0 : akuma_cd_q - CD_W'(1);
    assign ko_now       = (ryu_health == 8'd0) || (akuma_health == 8'd0) || (timer_q == 7'd0);
    assign match_done   = (ryu_wins_q == 2'(WINS_NEEDED)) || (akuma_wins_q == 2'(WINS_NEEDED))
                          || (round_q == 3'(MAX_ROUNDS));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        round_d        = round_q;
        ryu_wins_d     = ryu_wins_q;
        akuma_wins_d   = akuma_wins_q;
        winner_d       = winner_q;
        ryu_cd_d       = ryu_cd_q;
        akuma_cd_d     = akuma_cd_q;
        ryu_hit_d      = 1'b0;
        akuma_hit_d    = 1'b0;
        health_reset_d = 1'b0;
        enter_intro    = 1'b0;

        case (state_q)
            IDLE, MATCH_OVER: begin
                if (start) begin
                    round_d      = 3'd1;
                    ryu_wins_d   = 2'd0;
                    akuma_wins_d = 2'd0;
                    winner_d     = 2'b00;
                    enter_intro  = 1'b1;
                end
            end
            INTRO: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(INTRO_FRAMES - 1)) begin
                        state_d = FIGHT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIGHT: begin
                if (frame_tick) begin
                    if (ko_now) begin
                        state_d = KO;
                        cnt_d   = '0;
                        if (ryu_health > akuma_health) begin
                            winner_d = 2'b01;
                            if (ryu_wins_q != 2'd3) ryu_wins_d = ryu_wins_q + 2'd1;
                        end else if (akuma_health > ryu_health) begin
                            winner_d = 2'b10;
                            if (akuma_wins_q != 2'd3) akuma_wins_d = akuma_wins_q + 2'd1;
                        end else begin
                            winner_d = 2'b11;
                        end
                    end else begin
                        ryu_cd_d   = ryu_cd_dec;
                        akuma_cd_d = akuma_cd_dec;
                        if (ryu_hit_req && ryu_cd_dec == '0) begin
                            ryu_hit_d = 1'b1;
                            ryu_cd_d  = CD_W'(HIT_COOLDOWN);
                        end
                        if (akuma_hit_req && akuma_cd_dec == '0) begin
                            akuma_hit_d = 1'b1;
                            akuma_cd_d  = CD_W'(HIT_COOLDOWN);
                        end
                        if (cnt_q == CNT_W'(FRAMES_PER_SEC - 1)) begin
                            cnt_d = '0;
                            if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            KO: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(KO_FRAMES - 1)) begin
                        cnt_d = '0;
                        if (match_done) begin
                            state_d = MATCH_OVER;
                            if (ryu_wins_q > akuma_wins_q)      winner_d = 2'b01;
                            else if (akuma_wins_q > ryu_wins_q) winner_d = 2'b10;
                            else                                winner_d = 2'b11;
                        end else begin
                            round_d     = round_q + 3'd1;
                            enter_intro = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_intro) begin
            state_d        = INTRO;
            health_reset_d = 1'b1;
            timer_d        = 7'(ROUND_TIME);
            cnt_d          = '0;
            ryu_cd_d       = '0;
            akuma_cd_d     = '0;
        end

        fight_enable_d = (state_d == FIGHT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            timer_q        <= '0;
            round_q        <= '0;
            ryu_wins_q     <= '0;
            akuma_wins_q   <= '0;
            winner_q       <= '0;
            ryu_cd_q       <= '0;
            akuma_cd_q     <= '0;
            ryu_hit_q      <= 1'b0;
            akuma_hit_q    <= 1'b0;
            health_reset_q <= 1'b0;
            fight_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            round_q        <= round_d;
            ryu_wins_q     <= ryu_wins_d;
            akuma_wins_q   <= akuma_wins_d;
            winner_q       <= winner_d;
            ryu_cd_q       <= ryu_cd_d;
            akuma_cd_q     <= akuma_cd_d;
            ryu_hit_q      <= ryu_hit_d;
            akuma_hit_q    <= akuma_hit_d;
            health_reset_q <= health_reset_d;
            fight_enable_q <= fight_enable_d;
        end
    end

    assign ryu_hit      = ryu_hit_q;
    assign akuma_hit    = akuma_hit_q;
    assign health_reset = health_reset_q;
    assign fight_enable = fight_enable_q;
    assign timer_secs   = timer_q;
    assign round_num    = round_q;
    assign ryu_wins     = ryu_wins_q;
    assign akuma_wins   = akuma_wins_q;
    assign winner       = winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_fight_controller.sv
// Directed bench for fight_controller: round flow, hit cooldown, KO, timeout and match end.
module tb_fight_controller;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ryu_health = 8'd100;
    logic [7:0] akuma_health = 8'd100;
    logic       ryu_hit_req = 1'b0;
    logic       akuma_hit_req = 1'b0;
    logic       ryu_hit, akuma_hit, health_reset, fight_enable;
    logic [6:0] timer_secs;
    logic [2:0] round_num;
    logic [1:0] ryu_wins, akuma_wins, winner;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    fight_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
        .ryu_health(ryu_health), .akuma_health(akuma_health),
        .ryu_hit_req(ryu_hit_req), .akuma_hit_req(akuma_hit_req),
        .ryu_hit(ryu_hit), .akuma_hit(akuma_hit), .health_reset(health_reset),
        .fight_enable(fight_enable), .timer_secs(timer_secs), .round_num(round_num),
        .ryu_wins(ryu_wins), .akuma_wins(akuma_wins), .winner(winner), .state(state)
    );

    always #5 Clk = ~Clk;

    // Called at a negedge; returns at the next negedge with the tick's results visible.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", state); end
        total++; if ({ryu_hit, akuma_hit, health_reset, fight_enable, timer_secs, round_num, ryu_wins, akuma_wins, winner} !== 20'd0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%h want=0", {ryu_hit, akuma_hit, health_reset, fight_enable, timer_secs, round_num, ryu_wins, akuma_wins, winner});
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL idle_no_start got=%0d want=0", state); end
    endtask

    task automatic test_intro();
        pulse_start();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL start_state got=%0d want=1", state); end
        total++; if (health_reset !== 1'b1) begin bad++; $display("[TB] FAIL intro_health_reset got=%0d want=1", health_reset); end
        total++; if (timer_secs !== 7'd99) begin bad++; $display("[TB] FAIL intro_timer got=%0d want=99", timer_secs); end
        total++; if (round_num !== 3'd1) begin bad++; $display("[TB] FAIL intro_round got=%0d want=1", round_num); end
        tick();
        total++; if (health_reset !== 1'b0) begin bad++; $display("[TB] FAIL health_reset_single got=%0d want=0", health_reset); end
        ticks(118);
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL intro_119 got=%0d want=1", state); end
        tick();
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL fight_state got=%0d want=2", state); end
        total++; if (fight_enable !== 1'b1) begin bad++; $display("[TB] FAIL fight_enable got=%0d want=1", fight_enable); end
        total++; if (timer_secs !== 7'd99) begin bad++; $display("[TB] FAIL fight_timer got=%0d want=99", timer_secs); end
    endtask

    task automatic test_cooldown();
        akuma_hit_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            total++; if (akuma_hit !== ((i % 20) == 0)) begin bad++; $display("[TB] FAIL akuma_cooldown tick=%0d got=%0d want=%0d", i, akuma_hit, (i % 20) == 0); end
            total++; if (ryu_hit !== 1'b0) begin bad++; $display("[TB] FAIL ryu_quiet tick=%0d got=%0d want=0", i, ryu_hit); end
        end
        akuma_hit_req = 1'b0;
        ticks(25);
    endtask

    task automatic test_trade();
        ryu_hit_req = 1'b1;
        akuma_hit_req = 1'b1;
        tick();
        ryu_hit_req = 1'b0;
        akuma_hit_req = 1'b0;
        total++; if ({ryu_hit, akuma_hit} !== 2'b11) begin bad++; $display("[TB] FAIL trade got=%b want=11", {ryu_hit, akuma_hit}); end
        @(negedge Clk);
        total++; if ({ryu_hit, akuma_hit} !== 2'b00) begin bad++; $display("[TB] FAIL trade_one_cycle got=%b want=00", {ryu_hit, akuma_hit}); end
        // 76 fight ticks so far: one second elapsed
        total++; if (timer_secs !== 7'd98) begin bad++; $display("[TB] FAIL timer_after_76 got=%0d want=98", timer_secs); end
    endtask

    task automatic test_ko();
        int hits;
        akuma_health = 8'd0;
        tick();
        akuma_health = 8'd100;
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL ko_state got=%0d want=3", state); end
        total++; if (winner !== 2'b01) begin bad++; $display("[TB] FAIL ko_winner got=%b want=01", winner); end
        total++; if (ryu_wins !== 2'd1) begin bad++; $display("[TB] FAIL ko_ryu_wins got=%0d want=1", ryu_wins); end
        total++; if (fight_enable !== 1'b0) begin bad++; $display("[TB] FAIL ko_fight_enable got=%0d want=0", fight_enable); end
        hits = 0;
        akuma_hit_req = 1'b1;
        for (int i = 0; i < 179; i++) begin
            tick();
            if (akuma_hit) hits++;
        end
        akuma_hit_req = 1'b0;
        total++; if (hits !== 0) begin bad++; $display("[TB] FAIL ko_no_hits got=%0d want=0", hits); end
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL ko_179 got=%0d want=3", state); end
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL round2_state got=%0d want=1", state); end
        total++; if (round_num !== 3'd2) begin bad++; $display("[TB] FAIL round2_num got=%0d want=2", round_num); end
        total++; if (health_reset !== 1'b1) begin bad++; $display("[TB] FAIL round2_health_reset got=%0d want=1", health_reset); end
    endtask

    task automatic test_timeout();
        ticks(120);
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL r2_fight got=%0d want=2", state); end
        pulse_start();
        total++; if (state !== 3'd2 || round_num !== 3'd2) begin bad++; $display("[TB] FAIL start_ignored got=%0d/%0d want=2/2", state, round_num); end
        ticks(99 * 60);
        total++; if (timer_secs !== 7'd0) begin bad++; $display("[TB] FAIL timer_zero got=%0d want=0", timer_secs); end
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL timer_zero_state got=%0d want=2", state); end
        tick();
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL timeout_ko got=%0d want=3", state); end
        total++; if (winner !== 2'b11) begin bad++; $display("[TB] FAIL timeout_draw got=%b want=11", winner); end
        total++; if ({ryu_wins, akuma_wins} !== 4'b0100) begin bad++; $display("[TB] FAIL draw_no_credit got=%0d/%0d want=1/0", ryu_wins, akuma_wins); end
        ticks(180);
        total++; if (state !== 3'd1 || round_num !== 3'd3) begin bad++; $display("[TB] FAIL round3 got=%0d/%0d want=1/3", state, round_num); end
    endtask

    task automatic test_match_over();
        int hits;
        ticks(120);
        akuma_health = 8'd0;
        tick();
        akuma_health = 8'd100;
        total++; if (ryu_wins !== 2'd2) begin bad++; $display("[TB] FAIL r3_wins got=%0d want=2", ryu_wins); end
        ticks(180);
        total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL match_over got=%0d want=4", state); end
        total++; if (winner !== 2'b01) begin bad++; $display("[TB] FAIL match_winner got=%b want=01", winner); end
        total++; if (round_num !== 3'd3) begin bad++; $display("[TB] FAIL match_round got=%0d want=3", round_num); end
        hits = 0;
        ryu_hit_req = 1'b1;
        akuma_hit_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ryu_hit || akuma_hit) hits++;
        end
        ryu_hit_req = 1'b0;
        akuma_hit_req = 1'b0;
        total++; if (hits !== 0 || state !== 3'd4) begin bad++; $display("[TB] FAIL match_hold got=%0d/%0d want=0/4", hits, state); end
        pulse_start();
        total++; if (state !== 3'd1 || round_num !== 3'd1) begin bad++; $display("[TB] FAIL restart got=%0d/%0d want=1/1", state, round_num); end
        total++; if ({ryu_wins, akuma_wins, winner} !== 6'd0) begin bad++; $display("[TB] FAIL restart_clear got=%b want=000000", {ryu_wins, akuma_wins, winner}); end
        total++; if (health_reset !== 1'b1) begin bad++; $display("[TB] FAIL restart_health_reset got=%0d want=1", health_reset); end
    endtask

    task automatic test_reset_mid();
        ticks(10);
        Reset_n = 1'b0;
        #1;
        total++; if (state !== 3'd0 || round_num !== 3'd0 || timer_secs !== 7'd0) begin
            bad++; $display("[TB] FAIL mid_reset got=%0d/%0d/%0d want=0/0/0", state, round_num, timer_secs);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        ticks(5);
        total++; if (state !== 3'd0 || health_reset !== 1'b0) begin bad++; $display("[TB] FAIL post_reset got=%0d/%0d want=0/0", state, health_reset); end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_intro();
        test_cooldown();
        test_trade();
        test_ko();
        test_timeout();
        test_match_over();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fight_controller.md
Name: fight_controller

Overview:
Match sequencer for the two-fighter game. Owns round flow (intro, fight, KO, match over), the 99-second round clock and the win tally. Arbitrates punch-landed requests into one-frame hit pulses for the two health_bar instances, with per-defender hit cooldown. Sits between punch logic and the health bars; its fight_enable output gates fighter movement.

Parameters:
ROUND_TIME, 99, round clock start value in seconds (≤127)
FRAMES_PER_SEC, 60, frame_ticks per round-clock second
INTRO_FRAMES, 120, frames spent in INTRO before FIGHT
KO_FRAMES, 180, frames spent in KO before next round or match end
HIT_COOLDOWN, 20, frames a defender is immune after taking a hit
WINS_NEEDED, 2, round wins that end the match
MAX_ROUNDS, 5, rounds after which the match ends regardless

Ports:
Clk  in  1  system clock (MAX10_CLK1_50)
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per VGA frame, synchronous to Clk
start  in  1  one-Clk pulse; begins a match from IDLE or MATCH_OVER
ryu_health  in  8  Ryu health bar value
akuma_health  in  8  Akuma health bar value
ryu_hit_req  in  1  level: Akuma's punch overlaps Ryu
akuma_hit_req  in  1  level: Ryu's punch overlaps Akuma
ryu_hit  out  1  one-Clk pulse to Ryu health_bar
akuma_hit  out  1  one-Clk pulse to Akuma health_bar
health_reset  out  1  one-Clk pulse refilling both health bars
fight_enable  out  1  high only in FIGHT
timer_secs  out  7  round clock, seconds remaining
round_num  out  3  current round, 1-based; 0 in IDLE
ryu_wins  out  2  rounds won by Ryu
akuma_wins  out  2  rounds won by Akuma
winner  out  2  00 none, 01 Ryu, 10 Akuma, 11 draw (last round or match)
state  out  3  IDLE=0, INTRO=1, FIGHT=2, KO=3, MATCH_OVER=4

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; all counters 0. Release takes effect on next Clk edge.
- All outputs registered; decisions are made on Clk edges where frame_tick=1, except start and cooldown-free hit gating noted below.
- IDLE/MATCH_OVER + start: round_num←1, wins←0, winner←00, enter INTRO. start ignored in other states.
- INTRO entry: health_reset pulses one cycle; timer_secs←ROUND_TIME; frame counter←0; both cooldowns←0. After INTRO_FRAMES frame_ticks → FIGHT.
- FIGHT: frame counter increments per frame_tick; at FRAMES_PER_SEC-1 it wraps to 0 and timer_secs decrements (saturates at 0).
- Hit arbitration (FIGHT only): on a frame_tick, if X_hit_req=1 and X cooldown=0, X_hit pulses in the same cycle the registered output updates (1 Clk latency from the tick) and X cooldown←HIT_COOLDOWN; cooldown decrements per frame_tick otherwise. Both requests on the same tick: both granted (trade). Requests outside FIGHT or during cooldown are dropped, not queued.
- KO check, evaluated per frame_tick in FIGHT after hit grants of the previous tick: ryu_health=0 or akuma_health=0 or timer_secs=0 → KO. Round winner: higher health wins; equal health (incl. double KO) → draw, no win credited. winner reflects round result; wins saturate at 3.
- KO: fight_enable=0, no hits. After KO_FRAMES frame_ticks: if either wins=WINS_NEEDED or round_num=MAX_ROUNDS → MATCH_OVER with winner = more wins (equal → 11); else round_num+1, → INTRO.
- MATCH_OVER holds all outputs until start or reset.
- Reset asserted mid-round returns to IDLE immediately; no health_reset pulse until next INTRO.

Test Plan:
- Reset, start, 120 ticks → health_reset single pulse at INTRO entry, state=2, timer_secs=99, round_num=1, fight_enable=1.
- In FIGHT, hold akuma_hit_req for 50 ticks → akuma_hit pulses at ticks 0, 20, 40 only (3 pulses); ryu_hit stays 0.
- Both reqs high on same tick, cooldowns 0 → ryu_hit and akuma_hit pulse same cycle.
- Drive akuma_health=0 in FIGHT → next tick state=3, winner=01, ryu_wins=1; after 180 ticks state=1, round_num=2.
- Run FIGHT 99×60 ticks with equal health 100 → timer_secs=0, KO, winner=11, no win credited.
- Ryu wins rounds 1,2 → MATCH_OVER, winner=01; hit_reqs ignored; start restarts at round 1, wins 0.
